// File: rtl/gpu_pkg.sv
// Shared widths and state encoding for the pixel-plane VRAM write path.
package gpu_pkg;
    localparam int PX_ADDR_W = 17;
    localparam int PX_DATA_W = 24;

    typedef enum logic {
        WAIT  = 1'b0,
        DRAIN = 1'b1
    } sched_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 41
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic             push_en, pop_en;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]) &&
                     (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]);
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign dout    = mem[rd_ptr_reg[IDX_W-1:0]];

    assign wr_ptr_next = wr_ptr_reg + PTR_W'(push_en);
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop_en);

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg[IDX_W-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end
endmodule

// File: rtl/vram_px_write_scheduler.sv
// Buffers CPU pixel writes and commits them to VRAM only inside the post-frame drain window
// (or at any time in immediate mode), so the visible frame never tears.
module vram_px_write_scheduler
    import gpu_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = PX_ADDR_W,
    parameter int DATA_W        = PX_DATA_W,
    parameter int WINDOW_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wr_valid,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      wr_ready,
    input  logic                      frame_drawn,
    input  logic                      immediate,
    input  logic                      clr_spill,
    output logic                      vram_we,
    output logic [ADDR_W-1:0]         vram_addr,
    output logic [DATA_W-1:0]         vram_d,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      window_open,
    output logic                      spill
);
    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int FIFO_W = ADDR_W + DATA_W;
    localparam int CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WINDOW_CYCLES - 1);

    sched_state_t      state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              spill_reg, spill_next;
    logic              vram_we_reg;
    logic [ADDR_W-1:0] vram_addr_reg;
    logic [DATA_W-1:0] vram_d_reg;

    logic              fifo_full, fifo_empty;
    logic [FIFO_W-1:0] fifo_dout;
    logic [LVL_W-1:0]  fifo_level, level_after;
    logic              pop_en, push_fire, pop_fire, window_close, window_open_c;

    assign push_fire = wr_valid && !fifo_full;
    assign pop_fire  = pop_en && !fifo_empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_fire),
        .pop     (pop_fire),
        .din     ({wr_addr, wr_data}),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= WAIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // A frame_drawn inside the window only reloads the counter, so window_open never dips.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            WAIT: begin
                if (frame_drawn) begin
                    state_next = DRAIN;
                    cnt_next   = CNT_RELOAD;
                end
            end
            DRAIN: begin
                if (frame_drawn) begin
                    cnt_next = CNT_RELOAD;
                end else if (cnt_reg == '0) begin
                    state_next = WAIT;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = WAIT;
        endcase
    end

    always_comb begin
        window_open_c = (state_reg == DRAIN);
        pop_en        = window_open_c || immediate;
        window_close  = window_open_c && !frame_drawn && (cnt_reg == '0);
        level_after   = fifo_level + LVL_W'(push_fire) - LVL_W'(pop_fire);
        spill_next    = spill_reg;
        if (window_close && (level_after != '0) && !immediate) begin
            spill_next = 1'b1;
        end else if (clr_spill) begin
            spill_next = 1'b0;
        end
    end

    // The output register doubles as the FIFO read register: pop in cycle N, write in N+1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vram_we_reg   <= 1'b0;
            vram_addr_reg <= '0;
            vram_d_reg    <= '0;
            spill_reg     <= 1'b0;
        end else begin
            vram_we_reg <= pop_fire;
            spill_reg   <= spill_next;
            if (pop_fire) begin
                vram_addr_reg <= fifo_dout[FIFO_W-1:DATA_W];
                vram_d_reg    <= fifo_dout[DATA_W-1:0];
            end
        end
    end

    assign wr_ready    = !fifo_full;
    assign vram_we     = vram_we_reg;
    assign vram_addr   = vram_addr_reg;
    assign vram_d      = vram_d_reg;
    assign level       = fifo_level;
    assign window_open = window_open_c;
    assign spill       = spill_reg;
endmodule

// File: tb/tb_vram_px_write_scheduler.sv
// Scoreboard bench: a cycle-level occupancy/window model predicts every output; accepted writes are queued and popped by the monitor.
module tb_vram_px_write_scheduler;
    localparam int DEPTH = 16;
    localparam int AW    = 17;
    localparam int DW    = 24;
    localparam int W     = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          frame_drawn = 1'b0;
    logic          immediate = 1'b0;
    logic          clr_spill = 1'b0;
    logic          vram_we;
    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_d;
    logic [4:0]    level;
    logic          window_open;
    logic          spill;

    vram_px_write_scheduler #(
        .DEPTH         (DEPTH),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .WINDOW_CYCLES (W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .frame_drawn (frame_drawn),
        .immediate   (immediate),
        .clr_spill   (clr_spill),
        .vram_we     (vram_we),
        .vram_addr   (vram_addr),
        .vram_d      (vram_d),
        .level       (level),
        .window_open (window_open),
        .spill       (spill)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    int n_open = 0;

    // Reference model: occupancy count, open cycles remaining, sticky spill, expected write strobe.
    int m_count = 0;
    int m_rem = 0;
    bit m_spill = 1'b0;
    bit m_we = 1'b0;
    logic [AW+DW-1:0] sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        bit pop, acc;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_count = 0;
                m_rem = 0;
                m_spill = 1'b0;
                m_we = 1'b0;
                sb.delete();
            end else begin
                pop = ((m_rem > 0) || immediate) && (m_count > 0);
                acc = wr_valid && (m_count < DEPTH);
                if (acc) sb.push_back({wr_addr, wr_data});
                m_count = m_count + int'(acc) - int'(pop);
                m_we = pop;
                if (m_rem == 1 && !frame_drawn && m_count > 0 && !immediate) m_spill = 1'b1;
                else if (clr_spill) m_spill = 1'b0;
                if (frame_drawn) m_rem = W;
                else if (m_rem > 0) m_rem = m_rem - 1;
            end
        end
    end

    initial begin
        logic [AW+DW-1:0] exp;
        forever begin
            @(negedge clk);
            check("wr_ready", wr_ready, m_count < DEPTH);
            check("level", level, m_count);
            check("window_open", window_open, m_rem > 0);
            check("spill", spill, m_spill);
            check("vram_we", vram_we, m_we);
            if (window_open) n_open++;
            if (vram_we) begin
                n_writes++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h/%0h required=none", vram_addr, vram_d);
                end else begin
                    exp = sb.pop_front();
                    check("vram_addr", vram_addr, exp[AW+DW-1:DW]);
                    check("vram_d", vram_d, exp[DW-1:0]);
                    $display("write addr=%05h data=%06h t=%0t", vram_addr, vram_d, $time);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        bit done;
        done = 1'b0;
        wr_valid = 1'b1;
        wr_addr = a;
        wr_data = d;
        for (int i = 0; i < 100; i++) begin
            ok = wr_ready;
            @(negedge clk);
            if (ok) begin
                done = 1'b1;
                break;
            end
        end
        wr_valid = 1'b0;
        check("push_accepted", done, 1'b1);
    endtask

    task automatic pulse_fd();
        frame_drawn = 1'b1;
        @(negedge clk);
        frame_drawn = 1'b0;
    endtask

    task automatic drain_all();
        immediate = 1'b1;
        clr_spill = 1'b1;
        tick(DEPTH + 4);
        immediate = 1'b0;
        clr_spill = 1'b0;
        tick(W + 2);
        check("drained_level", level, 0);
    endtask

    initial begin
        int snap;
        tick(3);
        check("reset_vram_we", vram_we, 1'b0);
        check("reset_wr_ready", wr_ready, 1'b1);
        reset_n = 1'b1;
        tick(2);

        // Queued writes stay put until a frame_drawn opens the window.
        n_writes = 0;
        push_one(17'h00010, 24'hFF0000);
        push_one(17'h00011, 24'h00FF00);
        push_one(17'h00012, 24'h0000FF);
        tick(3);
        check("t1_level_held", level, 3);
        check("t1_no_writes", n_writes, 0);
        pulse_fd();
        tick(8);
        check("t1_writes", n_writes, 3);
        check("t1_level", level, 0);
        check("t1_spill", spill, 1'b0);

        // A 4-cycle window against 10 queued entries.
        for (int i = 0; i < 10; i++) push_one(AW'(17'h00100 + i), DW'($urandom));
        n_writes = 0;
        n_open = 0;
        pulse_fd();
        tick(8);
        check("t2_writes", n_writes, 4);
        check("t2_open_cycles", n_open, 4);
        check("t2_level", level, 6);
        check("t2_spill_set", spill, 1'b1);
        clr_spill = 1'b1;
        tick(1);
        clr_spill = 1'b0;
        tick(1);
        check("t2_spill_clr", spill, 1'b0);
        pulse_fd();
        tick(8);
        check("t2_level2", level, 2);
        drain_all();

        // Full FIFO refuses the 17th write until immediate mode makes room.
        for (int i = 0; i < DEPTH; i++) push_one(AW'(17'h00200 + i), DW'($urandom));
        wr_valid = 1'b1;
        wr_addr = 17'h00300;
        tick(3);
        check("t3_full_ready", wr_ready, 1'b0);
        check("t3_full_level", level, DEPTH);
        immediate = 1'b1;
        push_one(17'h00301, 24'hABCDEF);
        for (int i = 0; i < 4; i++) begin
            push_one(AW'(17'h00302 + i), DW'($urandom));
            check("t3_level_band", (level == 15) || (level == 16), 1'b1);
        end
        tick(DEPTH + 4);
        immediate = 1'b0;
        check("t3_level", level, 0);

        // Immediate mode: minimum two-cycle push-to-write latency.
        immediate = 1'b1;
        push_one(17'h1ABCD, 24'h123456);
        check("t4_we_early", vram_we, 1'b0);
        tick(1);
        check("t4_we", vram_we, 1'b1);
        check("t4_addr", vram_addr, 17'h1ABCD);
        check("t4_data", vram_d, 24'h123456);
        check("t4_window", window_open, 1'b0);
        immediate = 1'b0;
        tick(2);

        // Second frame_drawn at cnt==1 extends the window to 3+4 open cycles.
        for (int i = 0; i < 6; i++) push_one(AW'(17'h00400 + i), DW'($urandom));
        n_open = 0;
        pulse_fd();
        tick(2);
        pulse_fd();
        tick(8);
        check("t5_open_cycles", n_open, 7);
        check("t5_level", level, 0);

        // Asynchronous reset mid-drain.
        for (int i = 0; i < 5; i++) push_one(AW'(17'h00500 + i), DW'($urandom));
        pulse_fd();
        @(posedge clk);
        #1;
        check("t6_we_before", vram_we, 1'b1);
        reset_n = 1'b0;
        #1;
        check("t6_we_async", vram_we, 1'b0);
        check("t6_level", level, 0);
        check("t6_spill", spill, 1'b0);
        check("t6_window", window_open, 1'b0);
        tick(2);
        reset_n = 1'b1;
        snap = n_writes;
        pulse_fd();
        tick(10);
        check("t6_no_writes", n_writes, snap);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            wr_valid = ($urandom_range(0, 99) < 55);
            wr_addr = AW'($urandom_range(0, 131071));
            wr_data = DW'($urandom);
            frame_drawn = ($urandom_range(0, 99) < 4);
            clr_spill = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 99) < 3) immediate = !immediate;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        frame_drawn = 1'b0;
        drain_all();
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_px_write_scheduler.md
Name: vram_px_write_scheduler

Overview:
- Queues CPU writes to the pixel-plane VRAM (17-bit address, 24-bit RGB) and commits them only inside a per-frame drain window opened by the GPU frame-drawn interrupt. This prevents tearing on the pixel plane.
- Sits between the CPU memory interface and the write port of the pixel VRAM. The GPU read side (pixel engine) is untouched.
- An immediate mode bypasses the window for bulk initialisation.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- ADDR_W, 17, pixel VRAM address width.
- DATA_W, 24, pixel data width (8:8:8 RGB).
- WINDOW_CYCLES, 1024, drain window length in clk cycles; at least 1, at most 65535.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  CPU write request.
- wr_addr  in  ADDR_W  CPU write address.
- wr_data  in  DATA_W  CPU write data.
- wr_ready  out  1  FIFO can accept; a write transfers when wr_valid && wr_ready.
- frame_drawn  in  1  single-cycle pulse from the timing generator, already synchronous to clk.
- immediate  in  1  level; 1 = drain whenever the FIFO is non-empty, ignoring the window.
- clr_spill  in  1  pulse; clears spill.
- vram_we  out  1  registered pixel VRAM write enable.
- vram_addr  out  ADDR_W  registered write address.
- vram_d  out  DATA_W  registered write data.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- window_open  out  1  1 while in DRAIN.
- spill  out  1  sticky: a window closed with entries still queued.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert): FIFO empty, level=0, state WAIT, window counter 0, vram_we=0, vram_addr=0, vram_d=0, spill=0, window_open=0. wr_ready=1 after reset.
- FIFO: circular buffer, read/write pointers of $clog2(DEPTH)+1 bits, full/empty derived from the pointer MSB.
  - wr_ready = !full, combinational from registered state only; it does not depend on a same-cycle pop.
  - Push when wr_valid && wr_ready.
  - Pop when pop_en && !empty.
  - Simultaneous push and pop: level unchanged, both pointers advance.
- Pointer arithmetic wraps modulo 2*DEPTH.
- pop_en = (state==DRAIN) || immediate.
- Write latency: an entry popped in cycle N appears as vram_we=1 with its addr/data in cycle N+1.
  - vram_we=0 in any cycle after no pop; vram_addr and vram_d hold their last values.
  - Maximum throughput is one write per cycle. An entry pushed in cycle N can be popped no earlier than N+1, so the minimum push-to-vram_we latency is 2 cycles.
- State machine:
  - WAIT: on frame_drawn, load cnt=WINDOW_CYCLES-1 and go to DRAIN.
  - DRAIN, normal cycle: window_open=1; if cnt==0 go to WAIT, else cnt=cnt-1.
  - DRAIN, frame_drawn: reloads cnt=WINDOW_CYCLES-1 and stays in DRAIN (window extends; no glitch on window_open).
  - DRAIN with an empty FIFO still runs until cnt reaches 0; no early close.
  - A window therefore lasts exactly WINDOW_CYCLES cycles and allows at most WINDOW_CYCLES pops.
- spill:
  - Set in the cycle DRAIN exits to WAIT if the FIFO holds entries after that cycle's pop, and immediate=0.
  - clr_spill clears it. If set and clear coincide, set wins.
- immediate:
  - Toggling it mid-window does not affect the state machine or the counter.
  - immediate=1 in WAIT pops freely.
- A reset asserted mid-window or mid-drain discards all queued entries and forces vram_we=0 immediately (asynchronous).
- The FIFO storage array is not reset. Only the pointers are.

Decomposition:
- Shared package gpu_pkg holds PX_ADDR_W=17, PX_DATA_W=24, and the scheduler state enum {WAIT, DRAIN}.
- One sub-module, sync_fifo (parameterised DEPTH/WIDTH, push/pop/full/empty/level), instantiated with WIDTH=ADDR_W+DATA_W.
- The window FSM, counter, and output registers live in the top level.

Test Plan:
- Reset, then 3 pushes (addr 0x00010/0x00011/0x00012, data 0xFF0000/0x00FF00/0x0000FF) with immediate=0 and no frame_drawn -> vram_we stays 0, level=3; after a frame_drawn pulse, vram_we is high for 3 consecutive cycles starting 2 cycles after the pulse, in order; level returns to 0; spill=0.
- WINDOW_CYCLES=4, DEPTH=16, push 10 entries, one frame_drawn -> exactly 4 writes, window_open high 4 cycles, spill=1, level=6. clr_spill -> spill=0. Next frame_drawn drains 4 more (level=2).
- Push 16 entries with immediate=0 -> wr_ready=0 and a 17th wr_valid is not accepted. Then hold wr_valid with immediate=1 -> one push and one pop per cycle, level stays 15 or 16, all 17 writes appear in order.
- immediate=1, push 0x1ABCD/0x123456 -> vram_we=1 with that addr/data exactly 2 cycles after the push; window_open stays 0.
- In DRAIN with cnt=1, a second frame_drawn -> window extends to WINDOW_CYCLES more cycles, window_open never drops.
- 5 entries queued, reset_n asserted mid-window -> vram_we=0 within the same cycle, level=0, spill=0, state WAIT; no writes after release until a new push.
